// File: rtl/pdm_capture_ctrl_if.sv
// AXI4-Stream byte channel between the PDM capture controller and the PS-side FIFO.
// The master drives data/valid/last; the slave returns ready.
interface pdm_capture_ctrl_if;
    logic [7:0] m_axis_tdata;
    logic       m_axis_tvalid;
    logic       m_axis_tready;
    logic       m_axis_tlast;

    modport master (
        output m_axis_tdata,
        output m_axis_tvalid,
        output m_axis_tlast,
        input  m_axis_tready
    );

    modport slave (
        input  m_axis_tdata,
        input  m_axis_tvalid,
        input  m_axis_tlast,
        output m_axis_tready
    );
endinterface

// File: rtl/pdm_capture_ctrl.sv
// PDM capture sequencer: settle discard, packet framing, FWFT output FIFO, overflow flag.
// Define PDM_CAP_OVF_CNT_EN to enable the saturating dropped-sample counter.
module pdm_capture_ctrl #(
    parameter int FIFO_DEPTH     = 16,
    parameter int SETTLE_SAMPLES = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 stop,
    input  logic [15:0]          pkt_len,
    input  logic [7:0]           mic_data,
    input  logic                 mic_data_valid,
    output logic                 mic_en,
    output logic                 busy,
    output logic                 ovf_sticky,
    output logic [15:0]          ovf_count,
    pdm_capture_ctrl_if.master   axis
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int SW = $clog2(SETTLE_SAMPLES + 2);
    localparam logic [AW:0]   DEPTH_C     = (AW+1)'(FIFO_DEPTH);
    localparam logic [SW-1:0] SETTLE_LAST =
        SW'((SETTLE_SAMPLES > 0) ? SETTLE_SAMPLES - 1 : 0);

    typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE, FLUSH} state_e;

    state_e        state_q, state_d;
    logic [15:0]   len_q, len_d;
    logic [15:0]   idx_q, idx_d;
    logic [SW-1:0] settle_q, settle_d;
    logic          stop_pend_q, stop_pend_d;
    logic          ovf_q, ovf_d;

    logic [8:0]    mem_q [FIFO_DEPTH];
    logic [AW:0]   wr_ptr_q, rd_ptr_q, count;
    logic [8:0]    head;
    logic          full, empty, wr_en, rd_en, drop, tlast_w;

    assign count   = wr_ptr_q - rd_ptr_q;
    assign full    = (count == DEPTH_C);
    assign empty   = (count == '0);
    assign wr_en   = (state_q == CAPTURE) && mic_data_valid && !full;
    assign drop    = (state_q == CAPTURE) && mic_data_valid && full;
    assign rd_en   = !empty && axis.m_axis_tready;
    assign tlast_w = (idx_q == len_q - 16'd1);

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        idx_d       = idx_q;
        settle_d    = settle_q;
        stop_pend_d = stop_pend_q;
        ovf_d       = ovf_q | drop;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = (SETTLE_SAMPLES == 0) ? CAPTURE : SETTLE;
                    len_d       = (pkt_len == 16'd0) ? 16'd1 : pkt_len;
                    idx_d       = 16'd0;
                    settle_d    = '0;
                    stop_pend_d = 1'b0;
                    ovf_d       = 1'b0;
                end
            end
            SETTLE: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (mic_data_valid) begin
                    if (settle_q == SETTLE_LAST) begin
                        state_d  = CAPTURE;
                        settle_d = '0;
                    end else begin
                        settle_d = settle_q + 1'b1;
                    end
                end
            end
            CAPTURE: begin
                // A stop only takes effect on a packet boundary.
                if (wr_en) begin
                    idx_d = tlast_w ? 16'd0 : idx_q + 16'd1;
                    if (tlast_w && (stop || stop_pend_q)) begin
                        state_d     = FLUSH;
                        stop_pend_d = 1'b0;
                    end else if (stop) begin
                        stop_pend_d = 1'b1;
                    end
                end else if (stop) begin
                    if (idx_q == 16'd0) state_d = FLUSH;
                    else stop_pend_d = 1'b1;
                end
            end
            FLUSH: begin
                if (empty) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            len_q       <= 16'd1;
            idx_q       <= 16'd0;
            settle_q    <= '0;
            stop_pend_q <= 1'b0;
            ovf_q       <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
            settle_q    <= settle_d;
            stop_pend_q <= stop_pend_d;
            ovf_q       <= ovf_d;
            if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= {tlast_w, mic_data};
    end

`ifdef PDM_CAP_OVF_CNT_EN
    logic [15:0] ovf_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_cnt_q <= 16'h0000;
        end else if ((state_q == IDLE) && start) begin
            ovf_cnt_q <= 16'h0000;
        end else if (drop && (ovf_cnt_q != 16'hFFFF)) begin
            ovf_cnt_q <= ovf_cnt_q + 16'd1;
        end
    end

    assign ovf_count = ovf_cnt_q;
`else
    assign ovf_count = 16'h0000;
`endif

    assign head               = mem_q[rd_ptr_q[AW-1:0]];
    assign mic_en             = (state_q == SETTLE) || (state_q == CAPTURE);
    assign busy               = (state_q != IDLE);
    assign ovf_sticky         = ovf_q;
    assign axis.m_axis_tvalid = !empty;
    assign axis.m_axis_tdata  = empty ? 8'h00 : head[7:0];
    assign axis.m_axis_tlast  = !empty && head[8];
endmodule

// File: tb/tb_pdm_capture_ctrl.sv
// Scoreboard bench for pdm_capture_ctrl: a behavioural model queues expected beats,
// a negedge monitor pops and compares every accepted stream beat.
module tb_pdm_capture_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        stop;
    logic [15:0] pkt_len;
    logic [7:0]  mic_data;
    logic        mic_data_valid;
    logic        mic_en;
    logic        busy;
    logic        ovf_sticky;
    logic [15:0] ovf_count;

    pdm_capture_ctrl_if axis ();

    pdm_capture_ctrl #(
        .FIFO_DEPTH     (16),
        .SETTLE_SAMPLES (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .stop           (stop),
        .pkt_len        (pkt_len),
        .mic_data       (mic_data),
        .mic_data_valid (mic_data_valid),
        .mic_en         (mic_en),
        .busy           (busy),
        .ovf_sticky     (ovf_sticky),
        .ovf_count      (ovf_count),
        .axis           (axis.master)
    );

    always #5 clk = ~clk;

`ifdef PDM_CAP_OVF_CNT_EN
    localparam logic [15:0] OVF_EXP = 16'd4;
`else
    localparam logic [15:0] OVF_EXP = 16'd0;
`endif

    typedef enum {M_IDLE, M_SETTLE, M_CAP, M_FLUSH} mstate_e;

    int         checks = 0;
    int         errors = 0;
    logic [8:0] sb[$];
    mstate_e    m_state = M_IDLE;
    int         m_idx, m_len, m_settle;
    bit         m_pend;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && axis.m_axis_tvalid && axis.m_axis_tready) begin
            if (sb.size() == 0) begin
                check("extra_beat", {31'b0, axis.m_axis_tvalid}, 32'd0);
            end else begin
                check("beat", {23'b0, axis.m_axis_tlast, axis.m_axis_tdata},
                      {23'b0, sb.pop_front()});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int len);
        pkt_len = 16'(len);
        start   = 1'b1;
        tick();
        start    = 1'b0;
        m_state  = M_SETTLE;
        m_len    = (len == 0) ? 1 : len;
        m_idx    = 0;
        m_settle = 0;
        m_pend   = 1'b0;
    endtask

    task automatic do_stop();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        if (m_state == M_SETTLE) begin
            m_state = M_IDLE;
        end else if (m_state == M_CAP) begin
            if (m_idx == 0) m_state = M_FLUSH;
            else m_pend = 1'b1;
        end
    endtask

    // Queue size equals FIFO occupancy as seen at the next write edge.
    task automatic mic(input logic [7:0] d);
        bit last;
        mic_data       = d;
        mic_data_valid = 1'b1;
        if (m_state == M_SETTLE) begin
            m_settle++;
            if (m_settle == 4) m_state = M_CAP;
        end else if (m_state == M_CAP && sb.size() < 16) begin
            last = (m_idx == m_len - 1);
            sb.push_back({last, d});
            if (last) begin
                m_idx = 0;
                if (m_pend) begin
                    m_state = M_FLUSH;
                    m_pend  = 1'b0;
                end
            end else begin
                m_idx++;
            end
        end
        tick();
        mic_data_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 300 && (busy || sb.size() != 0); i++) tick();
        check(tag, {30'b0, busy, sb.size() != 0}, 32'd0);
        m_state = M_IDLE;
    endtask

    task automatic run_s1(input string tag);
        check({tag, "_mic_en_pre"}, {31'b0, mic_en}, 32'd0);
        do_start(8);
        check({tag, "_mic_en"}, {31'b0, mic_en}, 32'd1);
        for (int i = 0; i < 20; i++) mic(8'(i));
        do_stop();
        wait_idle({tag, "_drain"});
        check({tag, "_mic_en_end"}, {31'b0, mic_en}, 32'd0);
    endtask

    initial begin
        rst            = 1'b1;
        start          = 1'b0;
        stop           = 1'b0;
        pkt_len        = 16'd8;
        mic_data       = 8'h00;
        mic_data_valid = 1'b0;
        axis.m_axis_tready = 1'b1;
        tick();
        tick();
        check("rst_mic_en", {31'b0, mic_en}, 32'd0);
        check("rst_tvalid", {31'b0, axis.m_axis_tvalid}, 32'd0);
        check("rst_tlast", {31'b0, axis.m_axis_tlast}, 32'd0);
        check("rst_tdata", {24'b0, axis.m_axis_tdata}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_ovf", {31'b0, ovf_sticky}, 32'd0);
        check("rst_ovf_cnt", {16'b0, ovf_count}, 32'd0);
        rst = 1'b0;
        tick();

        run_s1("s1");

        do_start(8);
        for (int i = 0; i < 4; i++) mic(8'hA0 + 8'(i));
        for (int i = 0; i < 3; i++) mic(8'hB0 + 8'(i));
        do_stop();
        for (int i = 3; i < 13; i++) mic(8'hB0 + 8'(i));
        check("s2_mic_en", {31'b0, mic_en}, 32'd0);
        wait_idle("s2_drain");

        axis.m_axis_tready = 1'b0;
        do_start(8);
        for (int i = 0; i < 4; i++) mic(8'hC0);
        for (int i = 0; i < 20; i++) mic(8'h40 + 8'(i));
        tick();
        check("s3_ovf", {31'b0, ovf_sticky}, 32'd1);
        check("s3_ovf_cnt", {16'b0, ovf_count}, {16'b0, OVF_EXP});
        check("s3_tvalid", {31'b0, axis.m_axis_tvalid}, 32'd1);
        do_stop();
        axis.m_axis_tready = 1'b1;
        wait_idle("s3_drain");
        check("s3_ovf_hold", {31'b0, ovf_sticky}, 32'd1);

        axis.m_axis_tready = 1'b0;
        do_start(8);
        check("s4_ovf_clr", {31'b0, ovf_sticky}, 32'd0);
        check("s4_ovf_cnt_clr", {16'b0, ovf_count}, 32'd0);
        for (int i = 0; i < 4; i++) mic(8'hD0);
        for (int i = 0; i < 5; i++) mic(8'h60 + 8'(i));
        check("s4_tvalid_pre", {31'b0, axis.m_axis_tvalid}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("s4_mic_en", {31'b0, mic_en}, 32'd0);
        check("s4_tvalid", {31'b0, axis.m_axis_tvalid}, 32'd0);
        check("s4_tdata", {24'b0, axis.m_axis_tdata}, 32'd0);
        check("s4_tlast", {31'b0, axis.m_axis_tlast}, 32'd0);
        check("s4_busy", {31'b0, busy}, 32'd0);
        sb.delete();
        m_state = M_IDLE;
        tick();
        rst = 1'b0;
        axis.m_axis_tready = 1'b1;
        tick();
        run_s1("s4r");

        axis.m_axis_tready = 1'b0;
        do_start(0);
        for (int i = 0; i < 4; i++) mic(8'hE0);
        for (int i = 0; i < 3; i++) mic(8'h70 + 8'(i));
        do_stop();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("s5_flush_busy", {31'b0, busy}, 32'd1);
        check("s5_flush_mic_en", {31'b0, mic_en}, 32'd0);
        axis.m_axis_tready = 1'b1;
        wait_idle("s5_drain");
        do_start(8);
        mic(8'hF0);
        mic(8'hF1);
        do_stop();
        tick();
        check("s5_settle_stop", {31'b0, busy}, 32'd0);
        for (int i = 0; i < 4; i++) tick();
        check("s5_no_beats", {31'b0, axis.m_axis_tvalid}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end
endmodule
